alu_seq: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU. It adds a wider opcode set (EOR, logical shifts, multiply) and a Start/Done handshake, and holds result and flags in registers. A flag register is written only on flag-setting operations. The block sits in the execute stage, between the register-file read ports and the writeback mux; the condition-check logic reads its flag register.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/mul_iter.sv | 63 ++++++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU.
// Pure declarations: no latency.
// No flow control.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_LSL = 3'b101;
    localparam logic [2:0] ALU_LSR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle, low WIDTH bits kept.
// Latency: WIDTH busy cycles; done/product are valid combinationally in the last one.
// start is ignored while busy; no stall once running.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign busy     = (cnt_q != '0);
    assign acc_step = acc_q + (b_q[0] ? a_q : '0);
    // product is the accumulator after this cycle's step so the caller can register it on the final edge
    assign done     = busy && (cnt_q == CNT_W'(1));
    assign product  = acc_step;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (busy) begin
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
        end else if (start) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = CNT_W'(WIDTH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with Start/Done handshake and a conditionally written NZCV register.
// Latency: 1 cycle for all ops except MUL (WIDTH+1 cycles when the multiplier is present).
// Ready low while a multiply is in flight; Start during that time is dropped, not queued.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             SetFlags,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlag
);

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flag_q, flag_d;
    logic             setf_q, setf_d;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH:0]   lsr_ext;
    logic [7:0]       shamt;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;

    assign shamt   = SrcB[7:0];
    assign add_ext = {1'b0, SrcA} + {1'b0, SrcB};
    assign sub_ext = {1'b0, SrcA} - {1'b0, SrcB};
    // The extra bit catches the last bit shifted out; zero shift and over-range shifts leave it 0
    assign lsl_ext = {1'b0, SrcA} << shamt;
    assign lsr_ext = {SrcA, 1'b0} >> shamt;

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                alu_r = add_ext[WIDTH-1:0];
                alu_c = add_ext[WIDTH];
                alu_v = (SrcA[MSB] == SrcB[MSB]) && (alu_r[MSB] != SrcA[MSB]);
            end
            ALU_SUB: begin
                alu_r = sub_ext[WIDTH-1:0];
                alu_c = ~sub_ext[WIDTH];
                alu_v = (SrcA[MSB] != SrcB[MSB]) && (alu_r[MSB] != SrcA[MSB]);
            end
            ALU_AND: alu_r = SrcA & SrcB;
            ALU_ORR: alu_r = SrcA | SrcB;
            ALU_EOR: alu_r = SrcA ^ SrcB;
            ALU_LSL: begin
                alu_r = lsl_ext[WIDTH-1:0];
                alu_c = lsl_ext[WIDTH];
            end
            ALU_LSR: begin
                alu_r = lsr_ext[WIDTH:1];
                alu_c = lsr_ext[0];
            end
            ALU_MUL: alu_r = '0;
            default: alu_r = '0;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start),
                .a       (SrcA),
                .b       (SrcB),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_p)
            );
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_p    = '0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        result_d  = result_q;
        flag_d    = flag_q;
        setf_d    = setf_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    setf_d = SetFlags;
                    if (MUL_EN && (ALUControl == ALU_MUL)) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        done_d   = 1'b1;
                        result_d = alu_r;
                        if (SetFlags) begin
                            flag_d[FLAG_N] = alu_r[MSB];
                            flag_d[FLAG_Z] = (alu_r == '0);
                            flag_d[FLAG_C] = alu_c;
                            flag_d[FLAG_V] = alu_v;
                        end
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = mul_p;
                    if (setf_q) begin
                        flag_d = 4'b0000;
                        flag_d[FLAG_N] = mul_p[MSB];
                        flag_d[FLAG_Z] = (mul_p == '0);
                    end
                end else if (!mul_busy) begin
                    // Multiplier idle without finishing can only follow a glitch; recover rather than hang
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_q   <= 4'b0000;
            setf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            setf_q   <= setf_d;
        end
    end

    assign Ready     = (state_q == IDLE);
    assign Done      = done_q;
    assign ALUResult = result_q;
    assign ALUFlag   = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32, MUL_EN=1: vector table plus multiply and reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        SetFlags;
    logic        Ready;
    logic        Done;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlag;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .SetFlags   (SetFlags),
        .Ready      (Ready),
        .Done       (Done),
        .ALUResult  (ALUResult),
        .ALUFlag    (ALUFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one single-cycle op and checks it one edge later; leaves Start asserted.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sf,
                         input logic [31:0] exp_r, input logic [3:0] exp_f);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        SetFlags   = sf;
        Start      = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_done"},   64'(Done),      64'd1);
        check({name, "_ready"},  64'(Ready),     64'd1);
        check({name, "_result"}, 64'(ALUResult), 64'(exp_r));
        check({name, "_flags"},  64'(ALUFlag),   64'(exp_f));
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sf, input logic [31:0] exp_r, input logic [3:0] exp_f,
                           input bit stray);
        int done_at;
        bit ready_low;
        ALUControl = ALU_MUL;
        SrcA       = a;
        SrcB       = b;
        SetFlags   = sf;
        Start      = 1'b1;
        @(posedge clk);
        #1;
        Start     = 1'b0;
        SrcA      = 32'hFFFF_FFFF;
        SrcB      = 32'hFFFF_FFFF;
        done_at   = 0;
        ready_low = 1'b1;
        for (int i = 1; i <= 64 && done_at == 0; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (Done) done_at = i;
            else if (Ready) ready_low = 1'b0;
            if (stray && i == 5) begin
                ALUControl = ALU_ADD;
                SrcA       = 32'h0000_0001;
                SrcB       = 32'h0000_0001;
                SetFlags   = 1'b1;
                Start      = 1'b1;
            end
            if (stray && i == 6) Start = 1'b0;
        end
        check({name, "_latency"},   64'(done_at),   64'd33);
        check({name, "_ready_low"}, 64'(ready_low), 64'd1);
        check({name, "_ready_done"}, 64'(Ready),    64'd1);
        check({name, "_result"},    64'(ALUResult), 64'(exp_r));
        check({name, "_flags"},     64'(ALUFlag),   64'(exp_f));
    endtask

    initial begin
        int done_cnt;

        vecs[0]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001};
        vecs[1]  = '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b0110};
        vecs[2]  = '{ALU_SUB, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b1000};
        vecs[3]  = '{ALU_LSR, 32'h8000_0001, 32'h0000_0001, 1'b1, 32'h4000_0000, 4'b0010};
        vecs[4]  = '{ALU_LSL, 32'hFFFF_FFFF, 32'h0000_0028, 1'b1, 32'h0000_0000, 4'b0100};
        vecs[5]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001};
        vecs[6]  = '{ALU_AND, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_0000, 4'b1001};
        vecs[7]  = '{ALU_ORR, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF, 4'b0000};
        vecs[8]  = '{ALU_EOR, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'h00FF_FF00, 4'b0000};
        vecs[9]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110};
        vecs[10] = '{ALU_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011};
        vecs[11] = '{ALU_LSL, 32'h8000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 4'b0010};
        vecs[12] = '{ALU_LSL, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5678, 4'b0000};
        vecs[13] = '{ALU_LSR, 32'h8000_0000, 32'h0000_0020, 1'b1, 32'h0000_0000, 4'b0110};
        vecs[14] = '{ALU_LSL, 32'h0000_0001, 32'h0000_0020, 1'b1, 32'h0000_0000, 4'b0110};
        vecs[15] = '{ALU_LSR, 32'hFFFF_FFFF, 32'h0000_0021, 1'b1, 32'h0000_0000, 4'b0100};
        vecs[16] = '{ALU_EOR, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0100};
        vecs[17] = '{ALU_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b0111};
        vecs[18] = '{ALU_LSR, 32'h0000_FF00, 32'hFFFF_FF08, 1'b1, 32'h0000_00FF, 4'b0000};

        reset      = 1'b1;
        Start      = 1'b0;
        ALUControl = ALU_ADD;
        SrcA       = '0;
        SrcB       = '0;
        SetFlags   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  64'(Ready),     64'd1);
        check("rst_done",   64'(Done),      64'd0);
        check("rst_result", 64'(ALUResult), 64'd0);
        check("rst_flags",  64'(ALUFlag),   64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back table: Start stays high across entries
        for (int i = 0; i < 19; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf,
                  vecs[i].exp_r, vecs[i].exp_f);
        end
        Start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done_low", 64'(Done), 64'd0);

        run_mul("mul_stray", 32'h0001_0000, 32'h0001_0001, 1'b1, 32'h0001_0000, 4'b0000, 1'b1);
        do_op("start_in_done", ALU_ADD, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000);
        Start = 1'b0;
        @(posedge clk);
        #1;
        check("no_double_done", 64'(Done), 64'd0);

        run_mul("mul_zero", 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 4'b0100, 1'b0);
        run_mul("mul_nosf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 4'b0100, 1'b0);
        run_mul("mul_neg",  32'h8000_0000, 32'h0000_0003, 1'b1, 32'h8000_0000, 4'b1000, 1'b0);
        @(posedge clk);
        #1;
        check("mul_done_once", 64'(Done), 64'd0);

        // Asynchronous reset in the middle of a multiply
        do_op("pre_rst_add", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001);
        ALUControl = ALU_MUL;
        SrcA       = 32'd3;
        SrcB       = 32'd4;
        SetFlags   = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        check("mul_busy_ready", 64'(Ready), 64'd0);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_ready",  64'(Ready),     64'd1);
        check("midrst_done",   64'(Done),      64'd0);
        check("midrst_result", 64'(ALUResult), 64'd0);
        check("midrst_flags",  64'(ALUFlag),   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        do_op("post_rst_add", ALU_ADD, 32'd1, 32'd1, 1'b1, 32'd2, 4'b0000);
        Start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
